// File: rtl/eth_rx_pkt_reader_if.sv
// rtl/eth_rx_pkt_reader_if.sv - MAC receive port and output stream bundle
//
// Groups the MAC RX FIFO read port and the downstream frame stream.
//   MAC side : pkt_rx_avail/val/sop/eop/err/mod/data in, pkt_rx_ren out
//   Stream   : out_data/sop/eop/mod/err/valid out, out_ready in
// master = the reader; slave = the MAC + downstream environment.
interface eth_rx_pkt_reader_if;
  logic        pkt_rx_avail;
  logic        pkt_rx_val;
  logic        pkt_rx_sop;
  logic        pkt_rx_eop;
  logic        pkt_rx_err;
  logic [2:0]  pkt_rx_mod;
  logic [63:0] pkt_rx_data;
  logic        pkt_rx_ren;

  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [2:0]  out_mod;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  modport master (
    input  pkt_rx_avail, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err,
    input  pkt_rx_mod, pkt_rx_data,
    output pkt_rx_ren,
    output out_data, out_sop, out_eop, out_mod, out_err, out_valid,
    input  out_ready
  );

  modport slave (
    output pkt_rx_avail, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err,
    output pkt_rx_mod, pkt_rx_data,
    input  pkt_rx_ren,
    input  out_data, out_sop, out_eop, out_mod, out_err, out_valid,
    output out_ready
  );
endinterface

// File: rtl/eth_rx_pkt_reader.sv
// rtl/eth_rx_pkt_reader.sv - 10G MAC RX packet read controller
//
// Detects frame availability, issues pkt_rx_ren under a FIFO credit limit,
// buffers returned words in a show-ahead FIFO and streams them out with
// per-frame length and error reporting.
// Ports:
//   clk156m25, reset_156m25 : clock, async active-high reset
//   enable                  : allow new frames to start
//   bus (master)            : MAC read port + output stream
//   frame_done, frame_len   : completion pulse and byte length of last frame
//   proto_err               : sticky sop/eop sequencing violation
//   stat_frames_ok/err, stat_proto_err : counters, only with ETH_RX_STATS_EN
//                                        defined, otherwise constant 0
module eth_rx_pkt_reader #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int CNT_W           = 32
) (
  input  logic                 clk156m25,
  input  logic                 reset_156m25,
  input  logic                 enable,
  eth_rx_pkt_reader_if.master  bus,
  output logic                 frame_done,
  output logic [15:0]          frame_len,
  output logic                 proto_err,
  output logic [CNT_W-1:0]     stat_frames_ok,
  output logic [CNT_W-1:0]     stat_frames_err,
  output logic [CNT_W-1:0]     stat_proto_err
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
  } word_t;

  state_t      state, state_nx;
  word_t       mem [FIFO_DEPTH];
  word_t       wr_word, head;
  logic [AW:0] wr_ptr, rd_ptr, fifo_count;
  logic        ren, ren_q, credit_ok, in_frame;
  logic        wr_en, rd_en, viol, done_err;
  logic [15:0] byte_cnt, base, len_sat;
  logic [16:0] sum;
  logic [3:0]  eop_bytes;
  logic        oversize;

  assign fifo_count = wr_ptr - rd_ptr;
  // ren_q marks a word still in flight from the MAC; reserve a slot for it.
  assign credit_ok  = (int'(fifo_count) + int'(ren_q)) <= (FIFO_DEPTH - 2);

  always_ff @(posedge clk156m25 or posedge reset_156m25) begin
    if (reset_156m25) state <= IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ren      = 1'b0;
    case (state)
      IDLE: if (enable && bus.pkt_rx_avail) state_nx = READ;
      READ: begin
        // The eop word is arriving now; any further read would belong to the next frame.
        ren = credit_ok && !(bus.pkt_rx_val && bus.pkt_rx_eop);
        if (bus.pkt_rx_val && bus.pkt_rx_eop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.pkt_rx_ren = ren;

  // Classify each arriving word: discard, forward, or forward as a restart.
  always_comb begin
    wr_en = 1'b0;
    viol  = 1'b0;
    if (bus.pkt_rx_val) begin
      if (state == IDLE && !ren_q) begin
        viol = 1'b1;
      end else if (!bus.pkt_rx_sop && !in_frame) begin
        viol = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (bus.pkt_rx_sop && in_frame) viol = 1'b1;
      end
    end
  end

  always_comb begin
    eop_bytes = (bus.pkt_rx_mod == 3'd0) ? 4'd8 : {1'b0, bus.pkt_rx_mod};
    base      = bus.pkt_rx_sop ? 16'd0 : byte_cnt;
    sum       = {1'b0, base} + (bus.pkt_rx_eop ? {13'd0, eop_bytes} : 17'd8);
    len_sat   = sum[16] ? 16'hFFFF : sum[15:0];
    oversize  = int'(len_sat) > MAX_FRAME_BYTES;
    wr_word.data = bus.pkt_rx_data;
    wr_word.sop  = bus.pkt_rx_sop;
    wr_word.eop  = bus.pkt_rx_eop;
    wr_word.mod  = bus.pkt_rx_mod;
    wr_word.err  = bus.pkt_rx_eop && (bus.pkt_rx_err || oversize);
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_data  = head.data;
  assign bus.out_sop   = head.sop;
  assign bus.out_eop   = head.eop;
  assign bus.out_mod   = head.mod;
  assign bus.out_err   = head.err;
  assign rd_en         = bus.out_valid && bus.out_ready;

  // Storage is not reset: pointers define what is valid.
  always_ff @(posedge clk156m25) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      ren_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      in_frame   <= 1'b0;
      byte_cnt   <= 16'd0;
      frame_done <= 1'b0;
      frame_len  <= 16'd0;
      done_err   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      ren_q      <= ren;
      frame_done <= wr_en && bus.pkt_rx_eop;
      done_err   <= wr_word.err;
      if (viol) proto_err <= 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (bus.pkt_rx_eop) begin
          byte_cnt  <= 16'd0;
          in_frame  <= 1'b0;
          frame_len <= len_sat;
        end else begin
          byte_cnt  <= len_sat;
          in_frame  <= 1'b1;
        end
      end
    end
  end

`ifdef ETH_RX_STATS_EN
  always_ff @(posedge clk156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      stat_frames_ok  <= '0;
      stat_frames_err <= '0;
      stat_proto_err  <= '0;
    end else begin
      if (frame_done && !done_err && !(&stat_frames_ok))  stat_frames_ok  <= stat_frames_ok + 1'b1;
      if (frame_done && done_err && !(&stat_frames_err))  stat_frames_err <= stat_frames_err + 1'b1;
      if (viol && !(&stat_proto_err))                     stat_proto_err  <= stat_proto_err + 1'b1;
    end
  end
`else
  assign stat_frames_ok  = '0;
  assign stat_frames_err = '0;
  assign stat_proto_err  = '0;
`endif
endmodule

// File: doc/eth_rx_pkt_reader.md
Name: eth_rx_pkt_reader

Overview:
Read controller for the 10G MAC receive packet interface in the 156.25 MHz domain. It detects packet availability, sequences pkt_rx_ren under a credit scheme, and buffers returned words in a small FIFO. It forwards frames to downstream logic over a valid/ready stream and reports per-frame length and error status. It sits between the MAC RX FIFO and the receive-side packet processing.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 4.
MAX_FRAME_BYTES, 1518, frames longer than this are flagged oversize.
CNT_W, 32, width of statistics counters (optional feature only).

Ports:
clk156m25  input  1  clock
reset_156m25  input  1  asynchronous reset, active-high
enable  input  1  allow new frames to start
pkt_rx_avail  input  1  MAC has a frame ready
pkt_rx_val  input  1  MAC data word valid
pkt_rx_sop  input  1  start of packet
pkt_rx_eop  input  1  end of packet
pkt_rx_err  input  1  MAC-detected frame error, valid with eop
pkt_rx_mod  input  3  valid bytes in eop word; 0 means 8
pkt_rx_data  input  64  MAC data word
pkt_rx_ren  output  1  read enable to MAC
out_data  output  64  stream data
out_sop  output  1  stream start of frame
out_eop  output  1  stream end of frame
out_mod  output  3  stream byte modulus
out_err  output  1  frame error on eop word
out_valid  output  1  stream word valid
out_ready  input  1  downstream accept
frame_done  output  1  one-cycle pulse when eop word written into FIFO
frame_len  output  16  byte length of last completed frame
proto_err  output  1  sticky: sop/eop sequencing violation seen

Behaviour:
- Reset values: pkt_rx_ren=0, out_valid=0, frame_done=0, frame_len=0, proto_err=0, FIFO empty, state IDLE, byte counter 0.
- MAC read latency is 1: a ren sampled high at edge t yields pkt_rx_val at cycle t+1.
- States:
  - IDLE: go to READ when enable && pkt_rx_avail.
  - READ: stay until a val&&eop word is accepted, then go to IDLE.
- enable low mid-frame: the current frame completes; no new frame starts.
- pkt_rx_ren is combinational: state==READ && credit_ok && !(pkt_rx_val && pkt_rx_eop).
  - This means no read is issued in the eop cycle.
- Credit rule: credit_ok = fifo_count + inflight <= FIFO_DEPTH-2.
  - inflight = 1 if ren was high last cycle.
  - The FIFO never overflows. The bench asserts this.
- FIFO write: every pkt_rx_val word, except words discarded as described below. Write and read in the same cycle are allowed; occupancy is unchanged.
- FIFO read: on out_valid && out_ready. out_valid = FIFO non-empty. Output fields come straight from the FIFO head (zero-latency show-ahead).
- Byte count: +8 per non-eop word; eop word adds (mod==0 ? 8 : mod). Saturates at 16'hFFFF.
- Oversize: if the final count > MAX_FRAME_BYTES, the eop word is stored with err=1. out_err = pkt_rx_err | oversize, meaningful only on eop.
- Frame completion: frame_done pulses the cycle after the eop word is written. frame_len updates in that same cycle. The byte counter clears for the next frame.
- Protocol checks (each sets proto_err, cleared only by reset):
  - val without sop while not in-frame: word discarded.
  - sop while in-frame: the previous frame is left unterminated; the counter restarts and the word is forwarded as a new sop.
  - val in IDLE with no outstanding ren: word discarded.
- Asynchronous reset mid-frame or mid-stream: the FIFO is flushed and all state returns to reset values immediately.

Optional Feature:
Macro ETH_RX_STATS_EN.
- Defined: adds outputs stat_frames_ok, stat_frames_err and stat_proto_err, each CNT_W wide.
  - These are saturating counters, cleared by reset.
  - ok/err increments on each frame_done, selected by out_err of that frame.
  - proto increments on each protocol violation.
- Undefined: counter logic is absent and the three outputs are driven constant 0.

Test Plan:
- 64-byte frame (8 words, mod=0), out_ready=1 -> 8 stream words, sop on word 0, eop on word 7, out_err=0; frame_done pulse with frame_len=64; ren never high in the eop cycle.
- 61-byte frame (mod=5), out_ready held 0 -> ren stops once fifo_count+inflight reaches FIFO_DEPTH-1; no overflow. Release ready -> all 8 words delivered in order, frame_len=61.
- 1519-byte frame (190 words, mod=7) -> eop word has out_err=1, frame_len=1519. The same frame with pkt_rx_err=1 at 64 bytes -> out_err=1.
- Second sop injected mid-frame -> proto_err=1, counter restarts, new frame_len correct. Stray val without sop while idle -> word dropped, proto_err set.
- enable dropped at word 3 of a 16-word frame -> frame completes; avail held high afterwards -> ren stays 0.
- reset_156m25 pulsed with 3 words buffered -> out_valid=0 and ren=0 asynchronously; next frame after release is delivered cleanly. With ETH_RX_STATS_EN defined: 2 good frames + 1 errored frame -> ok=2, err=1.
